// File: rtl/hilo_mult_div.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI/LO registers.
// Fixed 33-cycle latency: 32 shift-add / restoring-divide steps plus one sign-fix cycle.
module hilo_mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic          div_q, div_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic          div_zero_q, div_zero_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [2*W-1:0] work_q, work_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          in_signed, in_sign_a, in_sign_b;
    logic [W-1:0]  in_mag_a, in_mag_b;
    logic [W:0]    mul_sum;
    logic [2*W-1:0] mul_next;
    logic [2*W:0]  div_sh;
    logic          div_ge;
    logic [W-1:0]  div_rem;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]  quot_fix, rem_fix;

    // Operand conditioning and one iteration step of each algorithm
    always_comb begin
        in_signed = ~op[0];
        in_sign_a = in_signed & src_a[W-1];
        in_sign_b = in_signed & src_b[W-1];
        in_mag_a  = in_sign_a ? (~src_a + W'(1)) : src_a;
        in_mag_b  = in_sign_b ? (~src_b + W'(1)) : src_b;

        // Multiply: work = {acc, multiplier}, opnd = multiplicand
        mul_sum  = {1'b0, work_q[2*W-1:W]} + {1'b0, opnd_q};
        mul_next = work_q[0] ? {mul_sum, work_q[W-1:1]}
                             : {1'b0, work_q[2*W-1:W], work_q[W-1:1]};

        // Divide: work = {rem, quot}, opnd = divisor; 33-bit trial subtract
        div_sh   = {work_q, 1'b0};
        div_ge   = div_sh[2*W:W] >= {1'b0, opnd_q};
        div_rem  = div_sh[2*W-1:W] - opnd_q;
        div_next = div_ge ? {div_rem, div_sh[W-1:1], 1'b1} : div_sh[2*W-1:0];

        prod_fix = (sign_a_q ^ sign_b_q) ? (~work_q + (2*W)'(1)) : work_q;
        quot_fix = (sign_a_q ^ sign_b_q) ? (~work_q[W-1:0] + W'(1)) : work_q[W-1:0];
        rem_fix  = sign_a_q ? (~work_q[2*W-1:W] + W'(1)) : work_q[2*W-1:W];
    end

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        a_d        = a_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CALC;
                    busy_d     = 1'b1;
                    div_d      = op[1];
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    div_zero_d = op[1] && (src_b == '0);
                    a_d        = src_a;
                    cnt_d      = '0;
                    opnd_d     = op[1] ? in_mag_b : in_mag_a;
                    work_d     = {{W{1'b0}}, (op[1] ? in_mag_a : in_mag_b)};
                end else begin
                    if (mthi) hi_d = src_a;
                    if (mtlo) lo_d = src_a;
                end
            end
            S_CALC: begin
                work_d = div_q ? div_next : mul_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (div_zero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            a_q        <= '0;
            opnd_q     <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            a_q        <= a_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_reg = hi_q;
    assign lo_reg = lo_q;

endmodule

// File: tb/tb_hilo_mult_div.sv
// Self-checking bench for hilo_mult_div: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_hilo_mult_div;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] hi_reg, lo_reg;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    hilo_mult_div dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi_reg(hi_reg), .lo_reg(lo_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] r;
        longint      sp;
        int          sq, sr;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r  = 64'(sp);
            end
            2'b01: r = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    r  = {32'(sr), 32'(sq)};
                end
            end
            default: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // inj: 0 none, 1 MTHI+MTLO mid-op, 2 second start mid-op, 3 moves alongside start
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inj, input int inj_at);
        logic [63:0] res;
        bit flow_ok, hold_ok;
        res = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        mthi = (inj == 3); mtlo = (inj == 3);
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check({tag, " busy@E0"}, 64'(busy), 64'd1);
        flow_ok = 1'b1; hold_ok = 1'b1;
        for (int n = 0; n < 33; n++) begin
            if (n == inj_at && inj == 1) begin
                mthi = 1'b1; mtlo = 1'b1; src_a = $urandom;
            end else if (n == inj_at && inj == 2) begin
                start = 1'b1; op = 2'($urandom_range(0, 3));
                src_a = $urandom; src_b = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (n < 32) begin
                if (!(busy === 1'b1 && done === 1'b0)) flow_ok = 1'b0;
                if (hi_reg !== exp_hi || lo_reg !== exp_lo) hold_ok = 1'b0;
            end
        end
        check({tag, " busy/done in flight"}, 64'(flow_ok), 64'd1);
        check({tag, " hilo held"}, 64'(hold_ok), 64'd1);
        check({tag, " done@E33"}, 64'(done), 64'd1);
        check({tag, " busy@E33"}, 64'(busy), 64'd0);
        check({tag, " hilo"}, {hi_reg, lo_reg}, res);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    task automatic do_move(input string tag, input logic mh, input logic ml, input logic [31:0] a);
        @(negedge clk);
        mthi = mh; mtlo = ml; src_a = a;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (mh) exp_hi = a;
        if (ml) exp_lo = a;
        check({tag, " hilo"}, {hi_reg, lo_reg}, {exp_hi, exp_lo});
        check({tag, " busy/done"}, {62'h0, busy, done}, 64'h0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit no_done;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hi", 64'(hi_reg), 64'h0);
        check("reset lo", 64'(lo_reg), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max const", {exp_hi, exp_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
        check("mult_m3x5 const", {hi_reg, lo_reg}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_m7d2 const", {hi_reg, lo_reg}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 0, 0);
        check("divu_by0 const", {hi_reg, lo_reg}, 64'h0000_0064_FFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf const", {hi_reg, lo_reg}, 64'h0000_0000_8000_0000);
        run_op("div_m5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0);
        do_move("mthi", 1'b1, 1'b0, 32'h1234_5678);
        do_move("mtlo", 1'b0, 1'b1, 32'hCAFE_F00D);
        do_move("mthi_mtlo", 1'b1, 1'b1, 32'hA5A5_0001);
        run_op("mult_mthi_busy", 2'b00, 32'd1234, 32'hFFFF_FF00, 1, 7);
        run_op("divu_2nd_start", 2'b11, 32'd9, 32'd4, 2, 4);
        check("divu_2nd_start const", {hi_reg, lo_reg}, 64'h0000_0001_0000_0002);
        run_op("start_with_move", 2'b01, 32'd3, 32'd11, 3, 0);
        run_op("fix_cycle_start", 2'b10, 32'd1000, 32'hFFFF_FFF9, 2, 32);

        // Reset in the middle of a MULTU aborts it with no done pulse
        do_move("pre_reset", 1'b1, 1'b1, 32'h5555_AAAA);
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd7; src_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("abort hilo", {hi_reg, lo_reg}, 64'h0);
        check("abort busy/done", {62'h0, busy, done}, 64'h0);
        no_done = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check("abort quiet", 64'(no_done), 64'd1);
        run_op("multu_7x6", 2'b01, 32'd7, 32'd6, 0, 0);
        check("multu_7x6 lo", 64'(lo_reg), 64'd42);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_move($sformatf("rnd_move%0d", i), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom);
            run_op($sformatf("rnd_op%0d", i), 2'($urandom_range(0, 3)), pick(), pick(),
                   $urandom_range(0, 3), $urandom_range(0, 32));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
